// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_pkg                                                         |
// | Purpose  : Shared widths, saturation bounds and the round/shift/saturate   |
// |            helper used by the CIC post-processing stages.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cic_pkg;

    // Working width of the generic helper; every product handed to it must
    // be narrower so that the rounding add cannot wrap.
    localparam int C_MAX_W   = 128;
    // Width of the shift operand accepted by the helper (shifts up to 255).
    localparam int C_SHIFT_W = 8;

    typedef struct packed {
        logic                      saturated;
        logic signed [C_MAX_W-1:0] value;
    } rss_result_t;

    // Signed product width of a signed sample times a zero-extended gain.
    function automatic int p_width(input int in_w, input int gain_w);
        return in_w + gain_w + 1;
    endfunction

    // Largest value representable in an out_w-bit two's-complement word.
    function automatic logic signed [C_MAX_W-1:0] sat_max(input int out_w);
        logic signed [C_MAX_W-1:0] one;
        one = 1;
        return (one <<< (out_w - 1)) - one;
    endfunction

    // Smallest value representable in an out_w-bit two's-complement word.
    function automatic logic signed [C_MAX_W-1:0] sat_min(input int out_w);
        logic signed [C_MAX_W-1:0] one;
        one = 1;
        return -(one <<< (out_w - 1));
    endfunction

    // Round half toward +inf, arithmetic shift right, then clamp to out_w bits.
    function automatic rss_result_t round_shift_saturate(
        input logic signed [C_MAX_W-1:0] p,
        input logic [C_SHIFT_W-1:0]      shift,
        input int                        out_w
    );
        logic signed [C_MAX_W-1:0] one;
        logic signed [C_MAX_W-1:0] r;
        logic signed [C_MAX_W-1:0] q;
        logic signed [C_MAX_W-1:0] hi;
        logic signed [C_MAX_W-1:0] lo;
        rss_result_t               res;
        one = 1;
        hi  = sat_max(out_w);
        lo  = sat_min(out_w);
        r   = p;
        if (shift != '0) begin
            r = p + (one <<< (shift - 1'b1));
        end
        q = r >>> shift;
        res.saturated = 1'b1;
        if (q > hi) begin
            res.value = hi;
        end else if (q < lo) begin
            res.value = lo;
        end else begin
            res.value     = q;
            res.saturated = 1'b0;
        end
        return res;
    endfunction

endpackage : cic_pkg
`default_nettype wire

// File: rtl/cic_output_scaler_round_saturate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : round_saturate                                                  |
// | Purpose  : Combinational rounding, arithmetic shift and saturation of the  |
// |            registered scaled product into the narrow output word.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module round_saturate
    import cic_pkg::*;
#(
    parameter int P_W   = 55,
    parameter int SH_W  = 6,
    parameter int OUT_W = 16
) (
    input  logic signed [P_W-1:0]   i_product,
    input  logic        [SH_W-1:0]  i_shift,
    output logic signed [OUT_W-1:0] o_result,
    output logic                    o_saturated
);

    rss_result_t w_res;
    logic        w_unused_hi;

    // Widen both operands into the helper's working width and evaluate.
    always_comb begin
        w_res = round_shift_saturate(C_MAX_W'(i_product), C_SHIFT_W'(i_shift), OUT_W);
    end

    // After clamping the upper bits are pure sign extension of the result.
    assign o_result    = w_res.value[OUT_W-1:0];
    assign o_saturated = w_res.saturated;
    assign w_unused_hi = ^w_res.value[C_MAX_W-1:OUT_W];

endmodule : round_saturate
`default_nettype wire

// File: rtl/cic_output_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_output_scaler                                               |
// | Purpose  : Gain, round, shift and saturate the wide CIC decimator output   |
// |            in a two-stage valid/ready pipeline with a sticky overflow.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cic_output_scaler
    import cic_pkg::*;
#(
    parameter int INPUT_LENGTH_BITS  = 36,
    parameter int OUTPUT_LENGTH_BITS = 16,
    parameter int GAIN_BITS          = 18,
    parameter int SHIFT_BITS         = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic signed [INPUT_LENGTH_BITS-1:0]  in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic        [GAIN_BITS-1:0]          gain,
    input  logic        [SHIFT_BITS-1:0]         shift,
    output logic signed [OUTPUT_LENGTH_BITS-1:0] out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overflow,
    input  logic                                 clear_overflow
);

    localparam int C_P_W  = p_width(INPUT_LENGTH_BITS, GAIN_BITS);
    // Wide enough to hold the clamped shift value C_P_W-1.
    localparam int C_SH_W = $clog2(C_P_W);

    logic signed [C_P_W-1:0]              w_product;
    logic        [31:0]                   w_shift_ext;
    logic        [C_SH_W-1:0]             w_shift_clamped;
    logic                                 w_s1_load;
    logic                                 w_s2_load;
    logic signed [OUTPUT_LENGTH_BITS-1:0] w_rs_result;
    logic                                 w_rs_saturated;

    logic                                 r_s1_valid;
    logic signed [C_P_W-1:0]              r_s1_product;
    logic        [C_SH_W-1:0]             r_s1_shift;
    logic signed [OUTPUT_LENGTH_BITS-1:0] r_out;
    logic                                 r_out_valid;
    logic                                 r_overflow;

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_product = C_P_W'(in) * C_P_W'($signed({1'b0, gain}));

    // Shifting by the full product width or more would only ever yield 0/-1.
    assign w_shift_ext     = 32'(shift);
    assign w_shift_clamped = (w_shift_ext > 32'(C_P_W - 1)) ? C_SH_W'(C_P_W - 1)
                                                             : C_SH_W'(w_shift_ext);

    // Each stage may advance when it is empty or its successor advances.
    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    round_saturate #(
        .P_W   (C_P_W),
        .SH_W  (C_SH_W),
        .OUT_W (OUTPUT_LENGTH_BITS)
    ) u_round_saturate (
        .i_product   (r_s1_product),
        .i_shift     (r_s1_shift),
        .o_result    (w_rs_result),
        .o_saturated (w_rs_saturated)
    );

    // Stage 1: capture the product and the gain/shift that came with the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_product <= '0;
            r_s1_shift   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_product <= w_product;
                r_s1_shift   <= w_shift_clamped;
            end
        end
    end

    // Stage 2: register the scaled word; out holds its value when S1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_rs_result;
            end
        end
    end

    // Sticky overflow: a saturating load into S2 takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_s2_load && r_s1_valid && w_rs_saturated) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule : cic_output_scaler
`default_nettype wire

// File: tb/tb_cic_output_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cic_output_scaler                                            |
// | Purpose  : Scoreboard bench for cic_output_scaler with a reference model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cic_output_scaler;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [35:0] din;
    logic               in_valid;
    logic               in_ready;
    logic        [17:0] gain;
    logic        [5:0]  shift;
    logic signed [15:0] dout;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic               clear_overflow;

    int     n_vec       = 0;
    int     n_bad       = 0;
    int     total_waits = 0;
    longint sb[$];

    cic_output_scaler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (din),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .gain           (gain),
        .shift          (shift),
        .out            (dout),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact product, floor((p + half) / 2^s), clamp to 16 bits.
    function automatic longint model(input longint x, input longint g, input int sh);
        longint p;
        longint num;
        longint d;
        longint q;
        int     s;
        p   = x * g;
        s   = (sh > 54) ? 54 : sh;
        d   = 64'sd1 <<< s;
        num = p + ((s > 0) ? (d / 2) : 0);
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic send(input longint x, input int g, input int sh);
        int waits;
        waits    = 0;
        din      = 36'(x);
        gain     = 18'(g);
        shift    = 6'(sh);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(x, longint'(g), sh));
        total_waits += waits;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        if (sb.size() != 0) check("drain_timeout", longint'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed output is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out: got %0d, expected no output", dout);
            end else begin
                check("out", longint'(dout), sb.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        din            = '0;
        in_valid       = 1'b0;
        gain           = '0;
        shift          = '0;
        out_ready      = 1'b1;
        clear_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", longint'(dout), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic scaling and two-edge latency.
        send(1000, 3, 2);
        check("lat_not_yet", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_valid", longint'(out_valid), 1);
        check("lat_value", longint'(dout), 750);
        check("lat_overflow", longint'(overflow), 0);
        drain();

        // Rounding half toward +inf, and gain of zero.
        send(5, 1, 1);
        send(-5, 1, 1);
        send(4, 1, 1);
        send(-4, 1, 1);
        send(12345, 0, 0);
        drain();
        check("gain0_overflow", longint'(overflow), 0);

        // Saturation, clear, and set-beats-clear.
        send(40000, 1, 0);
        drain();
        check("sat_hi_overflow", longint'(overflow), 1);
        send(-40000, 1, 0);
        drain();
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        check("clear_overflow", longint'(overflow), 0);
        send(40000, 1, 0);
        clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        clear_overflow = 1'b0;
        check("set_wins", longint'(overflow), 1);
        drain();

        // Backpressure: two words buffered, output held stable.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(longint'(i), 1, 0);
            end
        join_none
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2) begin
                check("stall_in_ready", longint'(in_ready), 0);
                check("stall_out_valid", longint'(out_valid), 1);
                check("stall_out", longint'(dout), 1);
            end
        end
        out_ready = 1'b1;
        wait fork;
        drain();

        // Full throughput with random words, gain and shift.
        total_waits = 0;
        for (int i = 0; i < 100; i++) begin
            logic [63:0]        raw;
            logic signed [35:0] v;
            int                 sh;
            raw = {$urandom(), $urandom()};
            v   = raw[35:0];
            sh  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(54, 30))
                                              : int'($urandom_range(63, 0));
            send(longint'(v), int'($urandom_range(262143, 0)), sh);
        end
        check("tput_in_ready_waits", longint'(total_waits), 0);
        check("tput_in_flight", longint'(sb.size()), 2);
        drain();

        // Reset with two words buffered and overflow set.
        out_ready = 1'b0;
        send(40000, 1, 0);
        send(8, 1, 0);
        check("pre_rst_overflow", longint'(overflow), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_out", longint'(dout), 0);
        check("mid_rst_overflow", longint'(overflow), 0);
        check("mid_rst_in_ready", longint'(in_ready), 1);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(123, 2, 1);
        drain();
        check("post_rst_empty", longint'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cic_output_scaler
`default_nettype wire

// File: doc/cic_output_scaler.md
Name: cic_output_scaler

Overview:
- Sits directly downstream of cic_decimator and consumes its wide two's-complement output.
- Applies a runtime gain and an arithmetic right shift to cancel the CIC (N·R)^M gain.
- Rounds, saturates to a narrow output word and drives a sticky overflow flag.
- Two-stage pipeline with full valid/ready backpressure, so it can feed a stalling consumer such as a FIFO or serializer.

Parameters:
- InputLengthBits, 36, width of the signed input word (matches the decimator OutputLengthBits).
- OutputLengthBits, 16, width of the signed output word.
- GainBits, 18, width of the unsigned integer gain.
- ShiftBits, 6, width of the shift-amount input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in  in  InputLengthBits  signed input sample
- in_valid  in  1  input word present
- in_ready  out  1  block accepts input this cycle
- gain  in  GainBits  unsigned multiplier, sampled with each accepted word
- shift  in  ShiftBits  right-shift amount, sampled with each accepted word
- out  out  OutputLengthBits  signed scaled sample
- out_valid  out  1  out holds a valid word
- out_ready  in  1  downstream accepts out this cycle
- overflow  out  1  sticky saturation flag
- clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, overflow=0, both stage-valid flags=0. in_ready is therefore 1 immediately after reset.
- Input handshake: a word is accepted on a rising edge where in_valid && in_ready. The output is consumed on an edge where out_valid && out_ready.
- Stage 1 (S1):
  - Registers product P = in × {0,gain} as a signed value of width P_W = InputLengthBits+GainBits+1.
  - Also registers shift, clamped to P_W-1.
  - Sets s1_valid.
- Stage 2 (S2):
  - Rounding: if shift>0, R = P + 2^(shift-1), computed at P_W+1 bits, so rounding is half toward +inf. If shift=0, R = P.
  - Q = R >>> shift (arithmetic).
  - Saturation: if Q > 2^(OutputLengthBits-1)-1, out=max. If Q < -2^(OutputLengthBits-1), out=min. Otherwise out = Q truncated.
  - Registers out and sets out_valid.
- Flow control:
  - s2_load = !out_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load (combinational from out_ready)
- S2 behaviour:
  - On s2_load, S2 takes S1's contents when s1_valid.
  - If S1 is empty, out_valid clears but out holds its last value.
- Latency: a word accepted at edge k appears on out with out_valid=1 after edge k+1 when there is no stall. Throughput is 1 word/cycle.
- Stall: with out_ready=0, the block holds exactly 2 words (S1 and S2), then in_ready=0. out and out_valid stay stable until consumed. No loss, no duplication, order preserved.
- Simultaneous events:
  - A pop and a push in the same cycle both proceed.
  - If saturation occurs on the same edge as clear_overflow=1, overflow ends at 1 (set wins).
  - overflow is set only when a saturating word is loaded into S2.
- gain=0 gives out=0 with no overflow.
- Changing gain or shift affects only words accepted after the change.
- Reset mid-operation: all buffered words are discarded and outputs return to their reset values asynchronously.

Decomposition:
- Package cic_pkg holds:
  - the function computing P_W;
  - the saturation bound constants as functions of OutputLengthBits;
  - a round_shift_saturate function shared with future stages.
- One combinational sub-module, round_saturate, implements S2's rounding and saturation datapath. The pipeline and handshake stay in cic_output_scaler.

Test Plan:
1. in=1000, gain=3, shift=2, out_ready=1 -> out=750 one edge after acceptance (2 edges total), overflow=0.
2. Rounding: gain=1, shift=1 with in=5 -> 3; in=-5 -> -2; in=4 -> 2; in=-4 -> -2.
3. Saturation: gain=1, shift=0 with in=40000 -> 32767 and overflow=1; in=-40000 -> -32768. Pulse clear_overflow -> overflow=0. Assert clear_overflow together with a saturating load -> overflow=1.
4. Backpressure:
   - Stimulus: stream 1,2,3,4,5 (gain=1, shift=0); hold out_ready=0 for 6 cycles, then release.
   - Required: in_ready=0 after 2 accepts, out_valid=1 with out stable throughout the stall, outputs exactly 1,2,3,4,5 in order.
5. Full throughput: continuous in_valid and out_ready with 100 random words and random gain/shift -> one output per cycle, all matching the reference model, in_ready constantly 1.
6. Reset mid-stream: assert rst_n=0 while 2 words are buffered -> out_valid=0, out=0, overflow=0 immediately. After release, the first new word emerges unaffected.
